// File: rtl/alarm_seq.sv
// Pattern-driven alarm sequencer: plays a stored table of {light, beat} steps,
// with repeat count, snooze pause and stop abort. All outputs are registered.
module alarm_seq #(
   parameter int BEAT_W     = 12,
   parameter int DEPTH      = 16,
   parameter int STEP_DIV   = 1,
   parameter int SNOOZE_CYC = 64,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              snooze,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [BEAT_W:0]   cfg_data,
   input  logic [AW-1:0]     cfg_len,
   input  logic [7:0]        cfg_repeat,
   output logic              light,
   output logic [BEAT_W-1:0] beat,
   output logic              busy,
   output logic              done
);

   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int SW = $clog2(SNOOZE_CYC + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PLAY   = 2'd1;
   localparam logic [1:0] S_SNOOZE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [AW-1:0]     step_q, step_d;
   logic [7:0]        pass_q, pass_d;
   logic [DW-1:0]     div_q, div_d;
   logic [SW-1:0]     snz_q, snz_d;
   logic [AW-1:0]     len_q, len_d;
   logic [7:0]        rep_q, rep_d;
   logic              light_q, light_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [BEAT_W:0]   mem_q [DEPTH];
   logic [DEPTH-1:0]  wr_sel;
   logic              load_en;
   logic [AW-1:0]     load_idx;

   // Pattern memory: per-entry write decode, cleared on reset.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
      assign wr_sel[gi] = cfg_we && (cfg_addr == AW'(gi));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
               mem_q[i] <= cfg_data;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      pass_d   = pass_q;
      div_d    = div_q;
      snz_d    = snz_q;
      len_d    = len_q;
      rep_d    = rep_q;
      done_d   = 1'b0;
      load_en  = 1'b0;
      load_idx = '0;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               state_d = S_PLAY;
               step_d  = '0;
               pass_d  = '0;
               div_d   = '0;
               len_d   = cfg_len;
               rep_d   = cfg_repeat;
               load_en = 1'b1;
            end
         end
         S_PLAY: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (snooze) begin
               state_d = S_SNOOZE;
               snz_d   = SW'(SNOOZE_CYC);
            end else if (div_q == DW'(STEP_DIV - 1)) begin
               div_d = '0;
               if (step_q == len_q) begin
                  pass_d = pass_q + 8'd1;
                  if ((rep_q != 8'd0) && (pass_d == rep_q)) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     step_d  = '0;
                     load_en = 1'b1;
                  end
               end else begin
                  step_d   = step_q + AW'(1);
                  load_en  = 1'b1;
                  load_idx = step_q + AW'(1);
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         S_SNOOZE: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (snz_q == SW'(1)) begin
               // Resume from the top of the pattern; pass count is kept.
               state_d = S_PLAY;
               step_d  = '0;
               div_d   = '0;
               load_en = 1'b1;
            end else begin
               snz_d = snz_q - SW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs follow the next state; entries are only sampled at step loads.
      light_d = light_q;
      beat_d  = beat_q;
      busy_d  = 1'b0;
      if (state_d == S_PLAY) begin
         busy_d = 1'b1;
         if (load_en) begin
            {light_d, beat_d} = mem_q[load_idx];
         end
      end else if (state_d == S_SNOOZE) begin
         busy_d  = 1'b1;
         light_d = 1'b0;
         beat_d  = '0;
      end else begin
         light_d = 1'b0;
         beat_d  = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         pass_q  <= '0;
         div_q   <= '0;
         snz_q   <= '0;
         len_q   <= '0;
         rep_q   <= '0;
         light_q <= 1'b0;
         beat_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         pass_q  <= pass_d;
         div_q   <= div_d;
         snz_q   <= snz_d;
         len_q   <= len_d;
         rep_q   <= rep_d;
         light_q <= light_d;
         beat_q  <= beat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign light = light_q;
   assign beat  = beat_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_alarm_seq.sv
// Scoreboard bench for alarm_seq: two instances (STEP_DIV 1 and 3) share stimulus;
// a time-based reference model predicts every cycle's outputs.
module tb_alarm_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, stop = 1'b0, snooze = 1'b0, cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0, cfg_len = '0;
   logic [12:0] cfg_data = '0;
   logic [7:0]  cfg_repeat = '0;

   logic        light0, busy0, done0, light1, busy1, done1;
   logic [11:0] beat0, beat1;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   alarm_seq u_dut0 (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .snooze(snooze),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
      .cfg_repeat(cfg_repeat), .light(light0), .beat(beat0), .busy(busy0), .done(done0)
   );

   alarm_seq #(.STEP_DIV(3)) u_dut1 (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .snooze(snooze),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
      .cfg_repeat(cfg_repeat), .light(light1), .beat(beat1), .busy(busy1), .done(done1)
   );

   typedef struct packed {
      logic [1:0]       l;
      logic [1:0][11:0] b;
      logic [1:0]       y;
      logic [1:0]       d;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: mode 0 idle, 1 play, 2 snooze; playback tracked as elapsed cycles in a pass.
   int          m_mode [2];
   int          m_t    [2];
   int          m_pass [2];
   int          m_left [2];
   int          m_len  [2];
   int          m_rep  [2];
   logic [12:0] m_cur  [2];
   logic [12:0] m_mem  [2][16];

   function automatic int div_of(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0; m_t[i] = 0; m_pass[i] = 0; m_left[i] = 0;
         m_len[i] = 0; m_rep[i] = 0; m_cur[i] = '0;
         for (int k = 0; k < 16; k++) m_mem[i][k] = '0;
      end
   endtask

   function automatic logic [14:0] model_step(int i);
      logic d;
      int   dv;
      d  = 1'b0;
      dv = div_of(i);
      case (m_mode[i])
         0: if (start && !stop) begin
               m_mode[i] = 1; m_t[i] = 0; m_pass[i] = 0;
               m_len[i] = int'(cfg_len); m_rep[i] = int'(cfg_repeat);
               m_cur[i] = m_mem[i][0];
            end
         1: if (stop) m_mode[i] = 0;
            else if (snooze) begin
               m_mode[i] = 2; m_left[i] = 64;
            end else begin
               m_t[i]++;
               if (m_t[i] == (m_len[i] + 1) * dv) begin
                  m_pass[i] = (m_pass[i] + 1) % 256;
                  if (m_rep[i] != 0 && m_pass[i] == m_rep[i]) begin
                     m_mode[i] = 0; d = 1'b1;
                  end else m_t[i] = 0;
               end
               if (m_mode[i] == 1 && (m_t[i] % dv) == 0) m_cur[i] = m_mem[i][m_t[i] / dv];
            end
         default: if (stop) m_mode[i] = 0;
            else begin
               m_left[i]--;
               if (m_left[i] == 0) begin
                  m_mode[i] = 1; m_t[i] = 0; m_cur[i] = m_mem[i][0];
               end
            end
      endcase
      if (cfg_we) m_mem[i][cfg_addr] = cfg_data;
      if (m_mode[i] == 1) return {d, 1'b1, m_cur[i]};
      if (m_mode[i] == 2) return {d, 1'b1, 13'd0};
      return {d, 1'b0, 13'd0};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic st, input logic sp, input logic sz, input logic we,
                      input logic [3:0] a, input logic [12:0] dat,
                      input logic [3:0] ln, input logic [7:0] rp);
      exp_t e;
      logic [14:0] r;
      @(negedge clock);
      #1;
      start = st; stop = sp; snooze = sz; cfg_we = we;
      cfg_addr = a; cfg_data = dat; cfg_len = ln; cfg_repeat = rp;
      for (int i = 0; i < 2; i++) begin
         r = model_step(i);
         e.d[i] = r[14]; e.y[i] = r[13]; e.l[i] = r[12]; e.b[i] = r[11:0];
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(int n);
      repeat (n) cyc(0, 0, 0, 0, 4'd0, 13'd0, 4'd0, 8'd0);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_light0"}, 32'(light0), 0);
      chk({tag, "_beat0"},  32'(beat0),  0);
      chk({tag, "_busy0"},  32'(busy0),  0);
      chk({tag, "_done0"},  32'(done0),  0);
      chk({tag, "_beat1"},  32'(beat1),  0);
      chk({tag, "_busy1"},  32'(busy1),  0);
   endtask

   // Monitor: one expected record per cycle, compared half a cycle after the edge.
   always @(negedge clock) begin
      if (!reset && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("light0", 32'(light0), 32'(e.l[0]));
         chk("beat0",  32'(beat0),  32'(e.b[0]));
         chk("busy0",  32'(busy0),  32'(e.y[0]));
         chk("done0",  32'(done0),  32'(e.d[0]));
         chk("light1", 32'(light1), 32'(e.l[1]));
         chk("beat1",  32'(beat1),  32'(e.b[1]));
         chk("busy1",  32'(busy1),  32'(e.y[1]));
         chk("done1",  32'(done1),  32'(e.d[1]));
         $display("cycle t=%0t exp0 l=%0b b=%03h y=%0b d=%0b | exp1 l=%0b b=%03h y=%0b d=%0b",
                  $time, e.l[0], e.b[0], e.y[0], e.d[0], e.l[1], e.b[1], e.y[1], e.d[1]);
      end
   end

   initial begin
      model_reset();
      #12;
      chk_zero("reset_state");
      @(negedge clock);
      #1 reset = 1'b0;

      // Basic three-step pattern, two passes.
      cyc(0, 0, 0, 1, 4'd0, 13'h1100, 4'd0, 8'd0);
      cyc(0, 0, 0, 1, 4'd1, 13'h0200, 4'd0, 8'd0);
      cyc(0, 0, 0, 1, 4'd2, 13'h0800, 4'd0, 8'd0);
      cyc(1, 0, 0, 0, 4'd0, 13'd0, 4'd2, 8'd2);
      idle(22);

      // Two-step single pass.
      cyc(1, 0, 0, 0, 4'd0, 13'd0, 4'd1, 8'd1);
      idle(9);

      // Endless play, snooze at step 2, resume, then stop.
      cyc(1, 0, 0, 0, 4'd0, 13'd0, 4'd3, 8'd0);
      idle(2);
      cyc(0, 0, 1, 0, 4'd0, 13'd0, 4'd0, 8'd0);
      idle(70);
      cyc(0, 1, 0, 0, 4'd0, 13'd0, 4'd0, 8'd0);
      idle(3);

      // start+stop together in idle; stop+snooze together in play.
      cyc(1, 1, 0, 0, 4'd0, 13'd0, 4'd2, 8'd0);
      idle(2);
      cyc(1, 0, 0, 0, 4'd0, 13'd0, 4'd2, 8'd0);
      idle(2);
      cyc(0, 1, 1, 0, 4'd0, 13'd0, 4'd0, 8'd0);
      idle(3);

      // Rewrite entry 1 while step 1 plays.
      cyc(1, 0, 0, 0, 4'd0, 13'd0, 4'd2, 8'd0);
      cyc(0, 0, 0, 1, 4'd1, 13'h1020, 4'd0, 8'd0);
      idle(12);
      cyc(0, 1, 0, 0, 4'd0, 13'd0, 4'd0, 8'd0);
      idle(2);

      // Reset during snooze: outputs drop before the next edge.
      cyc(1, 0, 0, 0, 4'd0, 13'd0, 4'd2, 8'd0);
      idle(1);
      cyc(0, 0, 1, 0, 4'd0, 13'd0, 4'd0, 8'd0);
      idle(5);
      @(negedge clock);
      #1 reset = 1'b1;
      start = 1'b0; stop = 1'b0; snooze = 1'b0; cfg_we = 1'b0;
      #1 chk_zero("async_reset");
      model_reset();
      @(negedge clock);
      #1 reset = 1'b0;
      cyc(1, 0, 0, 0, 4'd0, 13'd0, 4'd2, 8'd1);
      idle(12);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 2),
             ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10),
             4'($urandom_range(0, 15)), 13'($urandom),
             4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)));
      end

      repeat (4) @(negedge clock);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
